// File: rtl/bias_ctrl.sv
// bias_ctrl: fetches the two per-column bias scalars for a job from the
// unified buffer, then counts biased-output valids on both columns until
// each column has produced `rows` results, and pulses done.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, rows,          job start pulse; row count and bias address
//   bias_addr             sampled when start is accepted in IDLE
//   ub_rd_en, ub_rd_addr  unified-buffer read request (two reads per job)
//   ub_rd_valid,          unified-buffer read response, any latency >= 1
//   ub_rd_data
//   bias_scalar_out_1/2   captured bias scalars for column 1 / column 2
//   bias_Z_valid_in_1/2   per-column biased-output valids from the datapath
//   busy, done, err       status: not idle, completion pulse, sticky error
module bias_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned ROW_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W-1:0]         rows,
    input  logic [ADDR_W-1:0]        bias_addr,
    output logic                     ub_rd_en,
    output logic [ADDR_W-1:0]        ub_rd_addr,
    input  logic                     ub_rd_valid,
    input  logic [DATA_W-1:0]        ub_rd_data,
    output logic signed [DATA_W-1:0] bias_scalar_out_1,
    output logic signed [DATA_W-1:0] bias_scalar_out_2,
    input  logic                     bias_Z_valid_in_1,
    input  logic                     bias_Z_valid_in_2,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ROW_W-1:0]  cnt1_q, cnt1_d;
    logic [ROW_W-1:0]  cnt2_q, cnt2_d;
    logic [1:0]        resp_q, resp_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] b1_q, b1_d;
    logic [DATA_W-1:0] b2_q, b2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              err_set;
    logic              resp_window;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        base_d    = base_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        resp_d    = resp_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        err_d     = err_q;
        err_set   = 1'b0;

        // Read responses are accepted from RD0 until both have arrived;
        // anything else (idle, surplus responses) is a protocol error.
        resp_window = (state_q == RD0) || (state_q == RD1) || (state_q == WAIT);
        if (ub_rd_valid) begin
            if (resp_window && (resp_q != 2'd2)) begin
                if (resp_q == 2'd0) begin
                    b1_d = ub_rd_data;
                end else begin
                    b2_d = ub_rd_data;
                end
                resp_d = resp_q + 2'd1;
            end else begin
                err_set = 1'b1;
            end
        end

        // Column counters saturate at rows; an extra valid only flags err.
        if (state_q == RUN) begin
            if (bias_Z_valid_in_1) begin
                if (cnt1_q == rows_q) err_set = 1'b1;
                else                  cnt1_d  = cnt1_q + ROW_W'(1);
            end
            if (bias_Z_valid_in_2) begin
                if (cnt2_q == rows_q) err_set = 1'b1;
                else                  cnt2_d  = cnt2_q + ROW_W'(1);
            end
        end else if (bias_Z_valid_in_1 || bias_Z_valid_in_2) begin
            err_set = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (rows != '0) begin
                        rows_d    = rows;
                        base_d    = bias_addr;
                        cnt1_d    = '0;
                        cnt2_d    = '0;
                        resp_d    = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bias_addr;
                        state_d   = RD0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD0: begin
                rd_en_d   = 1'b1;
                rd_addr_d = base_q + ADDR_W'(1);
                state_d   = RD1;
            end
            RD1: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (resp_q == 2'd2) state_d = RUN;
            end
            RUN: begin
                // Completion uses the counts including this cycle's valids.
                if ((cnt1_d == rows_q) && (cnt2_d == rows_q)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stray valid in the same cycle as an accepted start still counts.
        if (err_set) err_d = 1'b1;

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            base_q    <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            resp_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            base_q    <= base_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            resp_q    <= resp_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ub_rd_en          = rd_en_q;
    assign ub_rd_addr        = rd_addr_q;
    assign bias_scalar_out_1 = b1_q;
    assign bias_scalar_out_2 = b2_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule
